// File: rtl/autobaud_pkg.sv
// Shared definitions for the multi-channel autobaud detector: FSM states and
// parameter defaults used by autobaud_multi and autobaud_match.
package autobaud_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_RX_DEF  = 3;
  localparam int CNT_W_DEF   = 14;
  localparam int SHIFT_DEF   = 5;
  localparam int DIV_W_DEF   = 8;
  localparam int MATCH_N_DEF = 3;
  localparam int TOL_DEF     = 0;

endpackage

// File: rtl/autobaud_match.sv
// Divisor-sample history (h[0] newest) and the tolerance comparator that
// declares a match when all samples are non-zero and close to the newest one.
module autobaud_match #(
  parameter int DIV_W   = 8,
  parameter int MATCH_N = 3,
  parameter int TOL     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic [DIV_W-1:0] sample_i,
  output logic [DIV_W-1:0] newest_o,
  output logic             match_o
);

  logic [DIV_W-1:0] hist_q [MATCH_N];
  logic [DIV_W-1:0] diff   [MATCH_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MATCH_N; i++) hist_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < MATCH_N; i++) hist_q[i] <= '0;
    end else if (shift_i) begin
      hist_q[0] <= sample_i;
      for (int i = 1; i < MATCH_N; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  // A zero sample means "not yet filled", so it can never take part in a match.
  always_comb begin
    match_o = 1'b1;
    for (int i = 0; i < MATCH_N; i++) begin
      diff[i] = (hist_q[i] >= hist_q[0]) ? hist_q[i] - hist_q[0] : hist_q[0] - hist_q[i];
      if (hist_q[i] == '0 || int'(diff[i]) > TOL) match_o = 1'b0;
    end
  end

  assign newest_o = hist_q[0];

endmodule

// File: rtl/autobaud_multi.sv
// Multi-channel autobaud: measures edge spacing on candidate RX lines, locks on
// MATCH_N agreeing divisor samples, then selects the channel once the line idles.
module autobaud_multi import autobaud_pkg::*; #(
  parameter int NUM_RX  = NUM_RX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int MATCH_N = MATCH_N_DEF,
  parameter int TOL     = TOL_DEF,
  localparam int SEL_W  = $clog2(NUM_RX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disabled,
  input  logic              rearm,
  input  logic [NUM_RX-1:0] rx_en,
  input  logic [NUM_RX-1:0] rx,
  output logic              wr,
  output logic [DIV_W-1:0]  div,
  output logic [SEL_W-1:0]  rx_sel,
  output logic              locked,
  output logic              done
);

  if (CNT_W < SHIFT + DIV_W) begin : g_bad_cnt_w
    $error("autobaud_multi: CNT_W must be >= SHIFT+DIV_W");
  end
  if (NUM_RX < 1 || NUM_RX > 7) begin : g_bad_num_rx
    $error("autobaud_multi: NUM_RX must be 1..7");
  end
  if (MATCH_N < 2 || MATCH_N > 8) begin : g_bad_match_n
    $error("autobaud_multi: MATCH_N must be 2..8");
  end

  state_e            state_q, state_d;
  logic [NUM_RX-1:0] last_q, edge_w;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  cand_q, cand_d, cand_w, sel_q, sel_d;
  logic [DIV_W-1:0]  div_q, div_d, sample_w, newest_w;
  logic              wr_q, wr_d, locked_q, locked_d, done_q, done_d;
  logic              any_edge, cnt_sat, match_w, hist_shift, sel_rx;

  assign edge_w     = (rx ^ last_q) & rx_en;
  assign any_edge   = |edge_w;
  assign cnt_sat    = &cnt_q;
  assign sample_w   = cnt_q[SHIFT+DIV_W-1:SHIFT];
  assign hist_shift = !rearm && (state_q == HUNT) && any_edge && !cnt_sat;

  // Scan downward so the lowest-indexed edge wins on simultaneous edges.
  always_comb begin
    cand_w = '0;
    for (int i = NUM_RX - 1; i >= 0; i--)
      if (edge_w[i]) cand_w = SEL_W'(i + 1);
  end

  always_comb begin
    sel_rx = 1'b0;
    for (int i = 0; i < NUM_RX; i++)
      if (cand_q == SEL_W'(i + 1)) sel_rx = rx[i];
  end

  autobaud_match #(
    .DIV_W   (DIV_W),
    .MATCH_N (MATCH_N),
    .TOL     (TOL)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (rearm),
    .shift_i  (hist_shift),
    .sample_i (sample_w),
    .newest_o (newest_w),
    .match_o  (match_w)
  );

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    sel_d    = sel_q;
    div_d    = div_q;
    locked_d = locked_q;
    done_d   = done_q;
    wr_d     = 1'b0;
    cnt_d    = any_edge ? '0 : (cnt_sat ? cnt_q : cnt_q + 1'b1);
    if (rearm) begin
      state_d  = HUNT;
      cand_d   = '0;
      sel_d    = '0;
      locked_d = 1'b0;
      done_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (any_edge) begin
            cand_d = cand_w;
            if (disabled) begin
              state_d  = LOCK;
              locked_d = 1'b1;
            end
          end else if (match_w && !disabled) begin
            wr_d     = 1'b1;
            div_d    = newest_w;
            locked_d = 1'b1;
            state_d  = LOCK;
          end
        end
        // Wait for a full counter period of idle-high on the chosen line.
        LOCK: begin
          if (disabled || (cnt_sat && sel_rx)) begin
            sel_d    = cand_q;
            done_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      last_q   <= '1;
      cnt_q    <= '0;
      cand_q   <= '0;
      sel_q    <= '0;
      div_q    <= '0;
      wr_q     <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= rx;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      sel_q    <= sel_d;
      div_q    <= div_d;
      wr_q     <= wr_d;
      locked_q <= locked_d;
      done_q   <= done_d;
    end
  end

  assign wr     = wr_q;
  assign div    = div_q;
  assign rx_sel = sel_q;
  assign locked = locked_q;
  assign done   = done_q;

endmodule

// File: tb/tb_autobaud_multi.sv
// Bench for autobaud_multi: two instances (TOL=0 and TOL=1) share stimulus;
// table vectors, hand sequences and random edge trains against a sample model.
module tb_autobaud_multi;
  localparam int NUM_RX  = 3;
  localparam int CNT_W   = 14;
  localparam int SHIFT   = 5;
  localparam int DIV_W   = 8;
  localparam int MATCH_N = 3;
  localparam int SEL_W   = $clog2(NUM_RX + 1);

  logic              clk = 1'b0;
  logic              rst, disabled, rearm;
  logic [NUM_RX-1:0] rx_en, rx;
  logic              wr0, wr1, locked0, locked1, done0, done1;
  logic [DIV_W-1:0]  div0, div1;
  logic [SEL_W-1:0]  sel0, sel1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int wr0_cnt = 0, wr1_cnt = 0, wr0_cyc = 0, wr1_cyc = 0, wr0_div = 0, wr1_div = 0;

  autobaud_multi u0 (
    .clk(clk), .rst(rst), .disabled(disabled), .rearm(rearm), .rx_en(rx_en), .rx(rx),
    .wr(wr0), .div(div0), .rx_sel(sel0), .locked(locked0), .done(done0)
  );

  autobaud_multi #(.TOL(1)) u1 (
    .clk(clk), .rst(rst), .disabled(disabled), .rearm(rearm), .rx_en(rx_en), .rx(rx),
    .wr(wr1), .div(div1), .rx_sel(sel1), .locked(locked1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr0 === 1'b1) begin
      wr0_cnt <= wr0_cnt + 1;
      wr0_cyc <= cyc;
      wr0_div <= int'(div0);
    end
    if (wr1 === 1'b1) begin
      wr1_cnt <= wr1_cnt + 1;
      wr1_cyc <= cyc;
      wr1_div <= int'(div1);
    end
  end

  typedef struct {
    logic [NUM_RX-1:0] mask;
    int g0, g1, g2, g3;
    int wr0, div0, idx0;
    int wr1, div1, idx1;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_rearm(output int r);
    rearm = 1'b1;
    r = cyc;
    tick(1);
    rearm = 1'b0;
  endtask

  // Toggle the masked lines so that edge j lands g[j] cycles after the previous event.
  task automatic run_edges(input logic [NUM_RX-1:0] mask, input int g[8], input int n,
                           input int start, output int e[8]);
    int prev;
    prev = start;
    for (int j = 0; j < 8; j++) e[j] = 0;
    for (int j = 0; j < n; j++) begin
      tick(prev + g[j] - cyc);
      rx = rx ^ mask;
      e[j] = cyc;
      prev = cyc;
    end
  endtask

  // Reference: spacing g gives counter value g-1; sample = that >> SHIFT.
  // Saturated spacings are dropped; lock on the first window of MATCH_N
  // recent samples that are all non-zero and within tol of the newest.
  function automatic void model(input int g[8], input int n, input int tol,
                                output int idx, output int dv);
    int s[$];
    int newest, d;
    bit ok;
    idx = -1;
    dv = 0;
    for (int j = 0; j < n; j++) begin
      if (g[j] - 1 < (1 << CNT_W) - 1) begin
        s.push_back(((g[j] - 1) >> SHIFT) % (1 << DIV_W));
        if (s.size() >= MATCH_N) begin
          newest = s[s.size() - 1];
          ok = 1'b1;
          for (int k = 0; k < MATCH_N; k++) begin
            d = s[s.size() - 1 - k] - newest;
            if (d < 0) d = -d;
            if (s[s.size() - 1 - k] == 0 || d > tol) ok = 1'b0;
          end
          if (ok) begin
            idx = j;
            dv = newest;
            return;
          end
        end
      end
    end
  endfunction

  initial begin
    int r, b0, b1, dsave, i0, d0, i1, d1, n, base;
    int g[8];
    int e[8];
    logic [NUM_RX-1:0] m;

    tbl[0] = '{3'b010, 257, 257, 257, 257, 1, 8, 2, 1, 8, 2};
    tbl[1] = '{3'b010, 100, 257, 289, 257, 0, 0, 0, 1, 8, 3};
    tbl[2] = '{3'b101, 257, 257, 257, 257, 1, 8, 2, 1, 8, 2};
    tbl[3] = '{3'b001,  40,  40,  40,  40, 1, 1, 2, 1, 1, 2};
    tbl[4] = '{3'b100,  20,  20,  20,  20, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{3'b001, 300, 257, 257, 257, 1, 8, 3, 1, 8, 2};
    tbl[6] = '{3'b010, 257, 321, 257, 321, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    disabled = 1'b0;
    rearm = 1'b0;
    rx_en = '1;
    rx = '1;
    tick(2);
    chk("rst_wr", int'(wr0), 0);
    chk("rst_div", int'(div0), 0);
    chk("rst_sel", int'(sel0), 0);
    chk("rst_locked", int'(locked0), 0);
    chk("rst_done", int'(done0), 0);
    rst = 1'b0;
    tick(2);

    // Four edges on rx[1], then a long idle-high stretch selects channel 2.
    b0 = wr0_cnt;
    do_rearm(r);
    g = '{257, 257, 257, 257, 0, 0, 0, 0};
    run_edges(3'b010, g, 4, r, e);
    tick(4);
    chk("basic_wr_count", wr0_cnt - b0, 1);
    chk("basic_div", wr0_div, 8);
    chk("basic_wr_cycle", wr0_cyc, e[2] + 2);
    chk("basic_locked", int'(locked0), 1);
    chk("basic_done_early", int'(done0), 0);
    tick(16384);
    chk("basic_sel", int'(sel0), 2);
    chk("basic_done", int'(done0), 1);
    chk("basic_locked_clr", int'(locked0), 0);

    // Rearm from DONE clears status but keeps div, then relocks.
    do_rearm(r);
    chk("rearm_sel", int'(sel0), 0);
    chk("rearm_done", int'(done0), 0);
    chk("rearm_div_hold", int'(div0), 8);
    b0 = wr0_cnt;
    run_edges(3'b010, g, 4, r, e);
    tick(10);
    chk("relock_wr_count", wr0_cnt - b0, 1);
    chk("relock_locked", int'(locked0), 1);

    // Asynchronous reset in the middle of LOCK.
    #3 rst = 1'b1;
    #1;
    chk("rst_lock_wr", int'(wr0), 0);
    chk("rst_lock_div", int'(div0), 0);
    chk("rst_lock_sel", int'(sel0), 0);
    chk("rst_lock_locked", int'(locked0), 0);
    chk("rst_lock_done", int'(done0), 0);
    tick(2);
    rst = 1'b0;
    b0 = wr0_cnt;
    tick(5);
    chk("rst_lock_after_done", int'(done0), 0);
    chk("rst_lock_after_wr", wr0_cnt - b0, 0);

    // Simultaneous edges on rx[0] and rx[2]: lowest index is chosen.
    do_rearm(r);
    run_edges(3'b101, g, 4, r, e);
    tick(16390);
    chk("simul_sel", int'(sel0), 1);
    chk("simul_done", int'(done0), 1);

    // Bypass mode: a single edge selects the channel with no divisor write.
    disabled = 1'b1;
    dsave = int'(div0);
    do_rearm(r);
    b0 = wr0_cnt;
    tick(3);
    rx = rx ^ 3'b100;
    for (int k = 0; k < 3 && done0 !== 1'b1; k++) tick(1);
    chk("bypass_done", int'(done0), 1);
    chk("bypass_sel", int'(sel0), 3);
    chk("bypass_wr_count", wr0_cnt - b0, 0);
    chk("bypass_div_hold", int'(div0), dsave);
    rx = rx ^ 3'b100;
    tick(1);
    disabled = 1'b0;

    // A saturated gap must not enter the history.
    do_rearm(r);
    b0 = wr0_cnt;
    g = '{257, 20000, 257, 0, 0, 0, 0, 0};
    run_edges(3'b001, g, 3, r, e);
    tick(4);
    chk("gap_no_lock", wr0_cnt - b0, 0);
    chk("gap_not_locked", int'(locked0), 0);
    g = '{257, 0, 0, 0, 0, 0, 0, 0};
    run_edges(3'b001, g, 1, e[2], e);
    tick(4);
    chk("gap_lock_count", wr0_cnt - b0, 1);
    chk("gap_lock_cycle", wr0_cyc, e[0] + 2);
    chk("gap_lock_div", wr0_div, 8);

    // A masked channel never produces an edge.
    rx_en = 3'b101;
    do_rearm(r);
    b0 = wr0_cnt;
    g = '{257, 257, 257, 257, 0, 0, 0, 0};
    run_edges(3'b010, g, 4, r, e);
    tick(4);
    chk("masked_wr_count", wr0_cnt - b0, 0);
    chk("masked_locked", int'(locked0), 0);
    rx_en = '1;

    for (int v = 0; v < 7; v++) begin
      b0 = wr0_cnt;
      b1 = wr1_cnt;
      do_rearm(r);
      g = '{tbl[v].g0, tbl[v].g1, tbl[v].g2, tbl[v].g3, 0, 0, 0, 0};
      run_edges(tbl[v].mask, g, 4, r, e);
      tick(4);
      chk($sformatf("vec%0d_wr_tol0", v), wr0_cnt - b0, tbl[v].wr0);
      chk($sformatf("vec%0d_wr_tol1", v), wr1_cnt - b1, tbl[v].wr1);
      if (tbl[v].wr0 != 0) begin
        chk($sformatf("vec%0d_div_tol0", v), wr0_div, tbl[v].div0);
        chk($sformatf("vec%0d_cyc_tol0", v), wr0_cyc, e[tbl[v].idx0] + 2);
      end
      if (tbl[v].wr1 != 0) begin
        chk($sformatf("vec%0d_div_tol1", v), wr1_div, tbl[v].div1);
        chk($sformatf("vec%0d_cyc_tol1", v), wr1_cyc, e[tbl[v].idx1] + 2);
      end
    end

    for (int t = 0; t < 10; t++) begin
      m = NUM_RX'(1 << $urandom_range(0, NUM_RX - 1));
      n = $urandom_range(3, 6);
      base = $urandom_range(34, 260);
      for (int j = 0; j < 8; j++)
        g[j] = ($urandom_range(0, 9) < 7) ? base : int'($urandom_range(34, 260));
      model(g, n, 0, i0, d0);
      model(g, n, 1, i1, d1);
      b0 = wr0_cnt;
      b1 = wr1_cnt;
      do_rearm(r);
      run_edges(m, g, n, r, e);
      tick(4);
      chk($sformatf("rnd%0d_wr_tol0", t), wr0_cnt - b0, (i0 >= 0) ? 1 : 0);
      chk($sformatf("rnd%0d_wr_tol1", t), wr1_cnt - b1, (i1 >= 0) ? 1 : 0);
      chk($sformatf("rnd%0d_locked_tol0", t), int'(locked0), (i0 >= 0) ? 1 : 0);
      if (i0 >= 0) begin
        chk($sformatf("rnd%0d_div_tol0", t), wr0_div, d0);
        chk($sformatf("rnd%0d_cyc_tol0", t), wr0_cyc, e[i0] + 2);
      end
      if (i1 >= 0) begin
        chk($sformatf("rnd%0d_div_tol1", t), wr1_div, d1);
        chk($sformatf("rnd%0d_cyc_tol1", t), wr1_cyc, e[i1] + 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/autobaud_multi.md
AUTOBAUD_MULTI -- requirements
Module: autobaud_multi

Interface
REQ-001 Parameter NUM_RX, default 3, number of candidate RX inputs (1..7).
REQ-002 Parameter CNT_W, default 14, width of the pulse-width counter.
REQ-003 Parameter SHIFT, default 5, right-shift applied to the pulse width to form a divisor sample.
REQ-004 Parameter DIV_W, default 8, divisor width; CNT_W >= SHIFT+DIV_W SHALL hold (elaboration check).
REQ-005 Parameter MATCH_N, default 3, number of consecutive samples that must agree (2..8).
REQ-006 Parameter TOL, default 0, maximum absolute difference between agreeing samples.
REQ-007 Ports, one per line:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  asynchronous, active-high reset.
- disabled  in  1  skip divisor detection; select channel only.
- rearm  in  1  single-cycle pulse that restarts detection.
- rx_en  in  NUM_RX  per-channel enable mask; a disabled channel never produces an edge.
- rx  in  NUM_RX  candidate RX lines, already synchronised.
- wr  out  1  one-cycle strobe; div is valid in that cycle.
- div  out  DIV_W  detected divisor.
- rx_sel  out  SEL_W=$clog2(NUM_RX+1)  selected channel index+1; 0 means none.
- locked  out  1  divisor found (or bypassed), waiting for the line to go idle.
- done  out  1  rx_sel is final.

Function
REQ-008 States SHALL be HUNT, LOCK and DONE; reset and rearm enter HUNT.
REQ-009 Edge detection: each enabled channel is registered every cycle; an edge is rx[i] != last[i] while rx_en[i]=1.
REQ-010 On simultaneous edges, the candidate channel SHALL be the lowest index with an edge.
REQ-011 Counter, in a no-edge cycle: increments and saturates at all-ones.
REQ-012 Counter, in an edge cycle: clears to 0.
REQ-013 HUNT, edge cycle: latch the candidate channel, then take the sample = counter[SHIFT+DIV_W-1:SHIFT].
- Counter not saturated: shift the sample into history h[0] (h[0] newest, h[MATCH_N-1] oldest).
- Counter saturated: history is unchanged.
REQ-014 HUNT, no-edge cycle: match holds when every h[i] != 0 and |h[i]-h[0]| <= TOL for all i.
- On match, next cycle: wr=1 for exactly one cycle, div=h[0], locked=1, state LOCK.
REQ-015 HUNT with disabled=1: the first edge latches the candidate channel and enters LOCK; wr is not asserted and div is unchanged.
REQ-016 LOCK: the counter clears on any enabled edge.
- Exit when disabled=1, or when the counter is saturated and the selected rx is 1.
- On exit, next cycle: rx_sel=candidate, done=1, locked=0, state DONE.
REQ-017 DONE: all outputs hold until rearm or rst.
REQ-018 rearm in any state SHALL, on the next clock:
- clear history, counter, rx_sel, locked, done and wr;
- load last with the current rx;
- enter HUNT;
- leave div unchanged.
REQ-019 rearm takes priority over all state actions in the same cycle.
REQ-020 Latency: a matching edge at cycle t gives history update at t+1, match evaluation at t+1 if no edge, wr at t+2.

Reset
REQ-021 On rst=1, asynchronously:
- wr=0, div=0, rx_sel=0, locked=0, done=0;
- history=0, counter=0, last=all-ones (idle-high, no spurious edge);
- state=HUNT.
REQ-022 Reset asserted mid-LOCK SHALL abort with no wr or done pulse.

Structure
REQ-023 Package autobaud_pkg SHALL hold the state enum and the parameter defaults.
REQ-024 Sub-module autobaud_match SHALL contain the MATCH_N-deep history shift register and the tolerance comparator, with output match.

Verification
REQ-025 Defaults; rx[1] toggles with 257-cycle spacing for 4 edges.
- Expect one wr pulse, div=0x08, locked=1.
- After 16384 idle-high cycles, expect rx_sel=2, done=1.
REQ-026 Edge spacings 257/289/257 (samples 8,9,8).
- TOL=1: lock with div=0x08.
- TOL=0: no wr.
REQ-027 rx[0] and rx[2] toggle in the same cycle, repeating at 257-cycle spacing -> final rx_sel=1.
REQ-028 disabled=1, single edge on rx[2] -> no wr; done=1 and rx_sel=3 within 3 cycles.
REQ-029 Gap of 20000 cycles inserted between valid edges -> history unchanged and no false lock; rx_en[1]=0 with rx[1] toggling -> no edge.
REQ-030 Reset and rearm:
- rearm in DONE, then 257-cycle pulses -> relock with a new wr.
- rst pulse mid-LOCK -> all outputs 0 immediately.
